// File: rtl/reset_sequencer.sv
// Ordered release of the clocking, SDRAM and camera reset domains, with done handshakes.
// Define RSEQ_WATCHDOG_EN to restart stages 1-2 when a done level drops while running.
module reset_sequencer #(
  parameter logic [31:0] DLY0      = 32'h1FFFFF,
  parameter logic [31:0] DLY1      = 32'h100000,
  parameter logic [31:0] DLY2      = 32'hF00000,
  parameter logic [31:0] TIMEOUT   = 32'h400000,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iDONE_1,
  input  logic       iDONE_2,
  input  logic       iSOFT_RST,
  output logic       oRST_0,
  output logic       oRST_1,
  output logic       oRST_2,
  output logic       oREADY,
  output logic       oFAULT,
  output logic [2:0] oSTATE
);

  typedef enum logic [2:0] {
    StHold  = 3'd0,
    StDly0  = 3'd1,
    StDly1  = 3'd2,
    StAck1  = 3'd3,
    StDly2  = 3'd4,
    StAck2  = 3'd5,
    StRun   = 3'd6,
    StFault = 3'd7
  } stateT;

  localparam logic [2:0] MaxRetry = MAX_RETRY[2:0];

  stateT       state;
  logic [31:0] cnt;
  logic [2:0]  retry;
  logic        runRestart;

`ifdef RSEQ_WATCHDOG_EN
  assign runRestart = iSOFT_RST | ~iDONE_1 | ~iDONE_2;
`else
  assign runRestart = iSOFT_RST;
`endif

  assign oSTATE = state;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state  <= StHold;
      cnt    <= '0;
      retry  <= '0;
      oRST_0 <= 1'b0;
      oRST_1 <= 1'b0;
      oRST_2 <= 1'b0;
      oREADY <= 1'b0;
      oFAULT <= 1'b0;
    end else begin
      case (state)
        StHold: begin
          state <= StDly0;
          cnt   <= '0;
        end
        StDly0: begin
          if (cnt == DLY0 - 32'd1) begin
            oRST_0 <= 1'b1;
            state  <= StDly1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        StDly1: begin
          if (cnt == DLY1 - 32'd1) begin
            oRST_1 <= 1'b1;
            state  <= StAck1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        StAck1: begin
          // A done seen on the timeout edge still wins.
          if (iDONE_1) begin
            retry <= '0;
            state <= StDly2;
            cnt   <= '0;
          end else if (cnt == TIMEOUT - 32'd1) begin
            oRST_1 <= 1'b0;
            cnt    <= '0;
            if (retry < MaxRetry) begin
              retry <= retry + 3'd1;
              state <= StDly1;
            end else begin
              oFAULT <= 1'b1;
              state  <= StFault;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        StDly2: begin
          if (cnt == DLY2 - 32'd1) begin
            oRST_2 <= 1'b1;
            state  <= StAck2;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        StAck2: begin
          if (iDONE_2) begin
            retry  <= '0;
            oREADY <= 1'b1;
            state  <= StRun;
            cnt    <= '0;
          end else if (cnt == TIMEOUT - 32'd1) begin
            oRST_2 <= 1'b0;
            cnt    <= '0;
            if (retry < MaxRetry) begin
              retry <= retry + 3'd1;
              state <= StDly2;
            end else begin
              oFAULT <= 1'b1;
              state  <= StFault;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        StRun: begin
          cnt <= '0;
          if (runRestart) begin
            oRST_1 <= 1'b0;
            oRST_2 <= 1'b0;
            oREADY <= 1'b0;
            oFAULT <= 1'b0;
            retry  <= '0;
            state  <= StDly1;
          end
        end
        StFault: begin
          cnt <= '0;
          // Failed stage stays held; only a software restart or iRST leaves here.
          if (iSOFT_RST) begin
            oRST_1 <= 1'b0;
            oRST_2 <= 1'b0;
            oREADY <= 1'b0;
            oFAULT <= 1'b0;
            retry  <= '0;
            state  <= StDly1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected output snapshots are queued per edge
// when stimulus is driven and compared one time unit after the matching clock edge.
module tb_reset_sequencer;

  localparam int D0 = 4;
  localparam int D1 = 6;
  localparam int D2 = 8;
  localparam int TO = 10;
  localparam int MR = 2;

  // Edge numbers of the nominal sequence, counted from the first edge with iRST low.
  localparam int E0 = D0 + 1;        // oRST_0 release
  localparam int E1 = E0 + D1;       // oRST_1 release, ACK1 entry
  localparam int E2 = E1 + 1 + D2;   // oRST_2 release, ACK2 entry
  localparam int E3 = E2 + 1;        // oREADY

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       iDONE_1 = 1'b1;
  logic       iDONE_2 = 1'b1;
  logic       iSOFT_RST = 1'b0;
  logic       oRST_0, oRST_1, oRST_2, oREADY, oFAULT;
  logic [2:0] oSTATE;
  logic [7:0] outv;

  typedef struct {
    int         at;
    logic [7:0] exp;
    string      tag;
  } expT;

  expT sb[$];
  expT cur;
  int  checks = 0;
  int  errors = 0;
  int  edgeCnt = 0;

  reset_sequencer #(
    .DLY0     (32'(D0)),
    .DLY1     (32'(D1)),
    .DLY2     (32'(D2)),
    .TIMEOUT  (32'(TO)),
    .MAX_RETRY(MR)
  ) dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iDONE_1  (iDONE_1),
    .iDONE_2  (iDONE_2),
    .iSOFT_RST(iSOFT_RST),
    .oRST_0   (oRST_0),
    .oRST_1   (oRST_1),
    .oRST_2   (oRST_2),
    .oREADY   (oREADY),
    .oFAULT   (oFAULT),
    .oSTATE   (oSTATE)
  );

  always #5 iCLK = ~iCLK;

  assign outv = {oRST_0, oRST_1, oRST_2, oREADY, oFAULT, oSTATE};

  function automatic logic [7:0] pk(input logic r0, input logic r1, input logic r2,
                                    input logic rdy, input logic flt, input logic [2:0] st);
    return {r0, r1, r2, rdy, flt, st};
  endfunction

  task automatic push(input int at, input logic [7:0] e, input string tag);
    expT x;
    x.at  = at;
    x.exp = e;
    x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
    edgeCnt++;
  endtask

  task automatic test_reset();
    int base;
    iRST = 1'b1;
    base = edgeCnt;
    for (int i = 1; i <= 3; i++) push(base + i, pk(0, 0, 0, 0, 0, 3'd0), "reset_hold");
    for (int i = 1; i <= 3; i++) begin
      tick();
      while (sb.size() > 0 && sb[0].at <= edgeCnt) begin
        cur = sb.pop_front();
        checks++;
        if (outv !== cur.exp) begin
          errors++;
          $display("FAIL %s edge %0d: got %b want %b", cur.tag, edgeCnt, outv, cur.exp);
        end
      end
    end
    iRST = 1'b0;
    edgeCnt = 0;
  endtask

  task automatic test_nominal();
    iDONE_1 = 1'b1;
    iDONE_2 = 1'b1;
    test_reset();
    push(1,      pk(0, 0, 0, 0, 0, 3'd1), "nom_dly0_entry");
    push(E0 - 1, pk(0, 0, 0, 0, 0, 3'd1), "nom_rst0_before");
    push(E0,     pk(1, 0, 0, 0, 0, 3'd2), "nom_rst0_rise");
    push(E1 - 1, pk(1, 0, 0, 0, 0, 3'd2), "nom_rst1_before");
    push(E1,     pk(1, 1, 0, 0, 0, 3'd3), "nom_rst1_rise");
    push(E1 + 1, pk(1, 1, 0, 0, 0, 3'd4), "nom_ack1_exit");
    push(E2 - 1, pk(1, 1, 0, 0, 0, 3'd4), "nom_rst2_before");
    push(E2,     pk(1, 1, 1, 0, 0, 3'd5), "nom_rst2_rise");
    push(E3,     pk(1, 1, 1, 1, 0, 3'd6), "nom_ready");
    push(E3 + 5, pk(1, 1, 1, 1, 0, 3'd6), "nom_run_hold");
    for (int i = 1; i <= E3 + 5; i++) begin
      tick();
      while (sb.size() > 0 && sb[0].at <= edgeCnt) begin
        cur = sb.pop_front();
        checks++;
        if (outv !== cur.exp) begin
          errors++;
          $display("FAIL %s edge %0d: got %b want %b", cur.tag, edgeCnt, outv, cur.exp);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int t;
    int a;
    iDONE_1 = 1'b0;
    iDONE_2 = 1'b1;
    test_reset();
    t = E1 + TO;
    a = t + D1 + 1;
    push(E1,         pk(1, 1, 0, 0, 0, 3'd3), "to_ack1_entry");
    push(t - 1,      pk(1, 1, 0, 0, 0, 3'd3), "to_before_expiry");
    push(t,          pk(1, 0, 0, 0, 0, 3'd2), "to_rst1_drop");
    push(t + D1 - 1, pk(1, 0, 0, 0, 0, 3'd2), "to_retry_wait");
    push(t + D1,     pk(1, 1, 0, 0, 0, 3'd3), "to_rst1_rerise");
    push(a,          pk(1, 1, 0, 0, 0, 3'd4), "to_ack1_second");
    push(a + D2,     pk(1, 1, 1, 0, 0, 3'd5), "to_rst2_rise");
    push(a + D2 + 1, pk(1, 1, 1, 1, 0, 3'd6), "to_ready_nofault");
    for (int i = 1; i <= a + D2 + 3; i++) begin
      tick();
      if (i == t) iDONE_1 = 1'b1;
      while (sb.size() > 0 && sb[0].at <= edgeCnt) begin
        cur = sb.pop_front();
        checks++;
        if (outv !== cur.exp) begin
          errors++;
          $display("FAIL %s edge %0d: got %b want %b", cur.tag, edgeCnt, outv, cur.exp);
        end
      end
    end
  endtask

  task automatic test_fault();
    int f;
    int rises;
    logic prev2;
    iDONE_1 = 1'b1;
    iDONE_2 = 1'b0;
    test_reset();
    for (int k = 0; k <= MR; k++) begin
      push(E2 + k * (TO + D2), pk(1, 1, 1, 0, 0, 3'd5), "flt_rst2_pulse");
      if (k < MR) push(E2 + k * (TO + D2) + TO, pk(1, 1, 0, 0, 0, 3'd4), "flt_rst2_retry");
    end
    f = E2 + MR * (TO + D2) + TO;
    push(f,     pk(1, 1, 0, 0, 1, 3'd7), "flt_enter");
    push(f + 5, pk(1, 1, 0, 0, 1, 3'd7), "flt_hold");
    rises = 0;
    prev2 = oRST_2;
    for (int i = 1; i <= f + 5; i++) begin
      tick();
      if (oRST_2 === 1'b1 && prev2 === 1'b0) rises++;
      prev2 = oRST_2;
      while (sb.size() > 0 && sb[0].at <= edgeCnt) begin
        cur = sb.pop_front();
        checks++;
        if (outv !== cur.exp) begin
          errors++;
          $display("FAIL %s edge %0d: got %b want %b", cur.tag, edgeCnt, outv, cur.exp);
        end
      end
    end
    checks++;
    if (rises !== MR + 1) begin
      errors++;
      $display("FAIL flt_pulse_count: got %0d want %0d", rises, MR + 1);
    end
  endtask

  // Starts from FAULT left by test_fault; also pokes iSOFT_RST once in DLY2, where it is ignored.
  task automatic test_soft_from_fault();
    int base;
    int r;
    iDONE_2 = 1'b1;
    iSOFT_RST = 1'b1;
    base = edgeCnt;
    r = base + 1 + D1 + 1 + D2 + 1;
    push(base + 1,          pk(1, 0, 0, 0, 0, 3'd2), "soft_fault_exit");
    push(base + 1 + D1,     pk(1, 1, 0, 0, 0, 3'd3), "soft_rst1_rise");
    push(base + 11,         pk(1, 1, 0, 0, 0, 3'd4), "soft_ignored_dly2");
    push(r - 1,             pk(1, 1, 1, 0, 0, 3'd5), "soft_rst2_rise");
    push(r,                 pk(1, 1, 1, 1, 0, 3'd6), "soft_ready");
    for (int i = 1; i <= r - base + 2; i++) begin
      tick();
      if (i == 1 || i == 11) iSOFT_RST = 1'b0;
      if (i == 10) iSOFT_RST = 1'b1;
      while (sb.size() > 0 && sb[0].at <= edgeCnt) begin
        cur = sb.pop_front();
        checks++;
        if (outv !== cur.exp) begin
          errors++;
          $display("FAIL %s edge %0d: got %b want %b", cur.tag, edgeCnt, outv, cur.exp);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    iDONE_1 = 1'b0;
    iDONE_2 = 1'b1;
    test_reset();
    push(E1,     pk(1, 1, 0, 0, 0, 3'd3), "mid_in_ack1");
    push(E1 + 2, pk(1, 1, 0, 0, 0, 3'd3), "mid_ack1_wait");
    for (int i = 1; i <= E1 + 3; i++) begin
      tick();
      if (i == E1 + 2) begin
        iRST = 1'b1;
        iDONE_1 = 1'b1;
        push(edgeCnt + 1, pk(0, 0, 0, 0, 0, 3'd0), "mid_reset_wins");
      end
      while (sb.size() > 0 && sb[0].at <= edgeCnt) begin
        cur = sb.pop_front();
        checks++;
        if (outv !== cur.exp) begin
          errors++;
          $display("FAIL %s edge %0d: got %b want %b", cur.tag, edgeCnt, outv, cur.exp);
        end
      end
    end
    iRST = 1'b0;
    edgeCnt = 0;
    push(E0, pk(1, 0, 0, 0, 0, 3'd2), "mid_restart_rst0");
    push(E3, pk(1, 1, 1, 1, 0, 3'd6), "mid_restart_ready");
    for (int i = 1; i <= E3 + 1; i++) begin
      tick();
      while (sb.size() > 0 && sb[0].at <= edgeCnt) begin
        cur = sb.pop_front();
        checks++;
        if (outv !== cur.exp) begin
          errors++;
          $display("FAIL %s edge %0d: got %b want %b", cur.tag, edgeCnt, outv, cur.exp);
        end
      end
    end
  endtask

  task automatic test_watchdog();
    int base;
    int len;
    base = edgeCnt;
    iDONE_1 = 1'b0;
`ifdef RSEQ_WATCHDOG_EN
    len = 1 + D1 + 1 + D2 + 1 + 1;
    push(base + 1,       pk(1, 0, 0, 0, 0, 3'd2), "wd_restart");
    push(base + len - 1, pk(1, 1, 1, 1, 0, 3'd6), "wd_ready_again");
`else
    len = 3;
    push(base + 1, pk(1, 1, 1, 1, 0, 3'd6), "wd_off_run_kept");
    push(base + 3, pk(1, 1, 1, 1, 0, 3'd6), "wd_off_run_hold");
`endif
    for (int i = 1; i <= len; i++) begin
      tick();
      if (i == 1) iDONE_1 = 1'b1;
      while (sb.size() > 0 && sb[0].at <= edgeCnt) begin
        cur = sb.pop_front();
        checks++;
        if (outv !== cur.exp) begin
          errors++;
          $display("FAIL %s edge %0d: got %b want %b", cur.tag, edgeCnt, outv, cur.exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_fault();
    test_soft_from_fault();
    test_mid_reset();
    test_watchdog();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
